// File: rtl/game_level_fsm_pkg.sv
// Shared types and helpers for the game flow controller: state encoding,
// saturation limits and the per-level enemy count.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START      = 3'd0,
    ST_PLAY       = 3'd1,
    ST_LOAD       = 3'd2,
    ST_PAUSED     = 3'd3,
    ST_VICTORY    = 3'd4,
    ST_DEATH      = 3'd5,
    ST_TRANSITION = 3'd6
  } game_state_e;

  localparam logic [15:0] SPEED_SAT = 16'h07FF;
  localparam logic [15:0] TREES_SAT = 16'd15;

  // Enemy count for a level, capped at maxEnemies.
  function automatic logic [2:0] enemies_for_level(input logic [2:0] lvl,
                                                   input int baseEnemies,
                                                   input int maxEnemies);
    int n;
    n = baseEnemies + int'(lvl);
    if (n > maxEnemies) n = maxEnemies;
    return n[2:0];
  endfunction

endpackage

// File: rtl/game_level_fsm_edge_detect.sv
// Rising-edge detector for a level button: pulse is high for the first
// cycle the input is seen high, using a registered copy of the input.
module edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) prev_q <= 1'b0;
    else         prev_q <= sig_i;
  end

  assign pulse_o = sig_i & ~prev_q;

endmodule

// File: rtl/game_level_fsm.sv
// Top-level game flow: start screen, N levels (load / play / transition),
// victory or death, optional pause. Tracks enemies and per-level difficulty.
module game_level_fsm
  import game_pkg::*;
#(
  parameter int NUM_LEVELS   = 4,
  parameter int BASE_ENEMIES = 2,
  parameter int MAX_ENEMIES  = 7,
  parameter int SHOT_W       = 3,
  parameter int SPEED_BASE   = 120,
  parameter int SPEED_STEP   = 120,
  parameter int TREES_BASE   = 8,
  parameter int LOAD_TICKS   = 120
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [2:0]        currLife,
  input  logic [23:0]       currentTime,
  input  logic [SHOT_W-1:0] shotEnemyCollision,
  input  logic              playerTrigger,
  input  logic              pauseTrigger,
  input  logic              transitionDone,
  input  logic              slowClk,
  output logic [2:0]        currentGameState,
  output logic [2:0]        level,
  output logic [2:0]        enemiesLeft,
  output logic [10:0]       curEnemySpeed,
  output logic [3:0]        tree_count,
  output logic              pause,
  output logic              start_screen,
  output logic              death_screen,
  output logic              transition_screen,
  output logic              victory_screen,
  output logic              newLevel,
  output logic              requestTime,
  output logic [10:0]       slowClkRequest
);

  localparam logic [2:0] LAST_LEVEL = 3'(NUM_LEVELS - 1);

  game_state_e state_q, state_d;
  logic [2:0]  level_q, level_d;
  logic [2:0]  left_q, left_d;
  logic        loadFirst_q, loadFirst_d;

  logic        trigPulse, pausePulse, playerDead;
  logic [7:0]  kills;
  logic [2:0]  enemies0;
  logic [15:0] speedSum, treeSum;

  edge_detect u_trig_edge (
    .clk     (clk),
    .resetN  (resetN),
    .sig_i   (playerTrigger),
    .pulse_o (trigPulse)
  );

  edge_detect u_pause_edge (
    .clk     (clk),
    .resetN  (resetN),
    .sig_i   (pauseTrigger),
    .pulse_o (pausePulse)
  );

  assign enemies0   = enemies_for_level(3'd0, BASE_ENEMIES, MAX_ENEMIES);
  assign playerDead = (currLife == 3'd0) || (currentTime == 24'd0);

  always_comb begin
    kills = 8'd0;
    for (int i = 0; i < SHOT_W; i++) kills = kills + 8'(shotEnemyCollision[i]);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_START;
      level_q     <= 3'd0;
      left_q      <= enemies0;
      loadFirst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      left_q      <= left_d;
      loadFirst_q <= loadFirst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    left_d      = left_q;
    loadFirst_d = 1'b0;
    case (state_q)
      ST_START: begin
        if (trigPulse) begin
          level_d     = 3'd0;
          left_d      = enemies0;
          loadFirst_d = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // The first LOAD cycle carries the timer request, so slowClk is not accepted yet.
        if (slowClk && !loadFirst_q) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (kills >= {5'd0, left_q}) begin
          left_d  = 3'd0;
          state_d = (level_q == LAST_LEVEL) ? ST_VICTORY : ST_TRANSITION;
        end else begin
          left_d = left_q - kills[2:0];
          if (playerDead)      state_d = ST_DEATH;
          else if (pausePulse) state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pausePulse) state_d = ST_PLAY;
      end
      ST_TRANSITION: begin
        if (transitionDone) begin
          level_d     = level_q + 3'd1;
          left_d      = enemies_for_level(level_q + 3'd1, BASE_ENEMIES, MAX_ENEMIES);
          loadFirst_d = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_VICTORY, ST_DEATH: begin
        if (trigPulse) begin
          level_d = 3'd0;
          left_d  = enemies0;
          state_d = ST_START;
        end
      end
      default: begin
        level_d = 3'd0;
        left_d  = enemies0;
        state_d = ST_START;
      end
    endcase
  end

  always_comb begin
    speedSum = 16'(SPEED_BASE) + 16'(level_q) * 16'(SPEED_STEP);
    treeSum  = 16'(TREES_BASE) + 16'(level_q);
  end

  assign curEnemySpeed     = (speedSum > SPEED_SAT) ? SPEED_SAT[10:0] : speedSum[10:0];
  assign tree_count        = (treeSum > TREES_SAT) ? TREES_SAT[3:0] : treeSum[3:0];

  assign currentGameState  = state_q;
  assign level             = level_q;
  assign enemiesLeft       = left_q;
  assign pause             = (state_q != ST_PLAY);
  assign start_screen      = (state_q == ST_START);
  assign death_screen      = (state_q == ST_DEATH);
  assign transition_screen = (state_q == ST_TRANSITION);
  assign victory_screen    = (state_q == ST_VICTORY);
  assign newLevel          = (state_q == ST_LOAD);
  assign requestTime       = (state_q == ST_LOAD) && loadFirst_q;
  assign slowClkRequest    = requestTime ? 11'(LOAD_TICKS) : 11'd0;

endmodule

// File: tb/tb_game_level_fsm.sv
// Scoreboard bench for game_level_fsm: stimulus pushes expected output
// snapshots, a monitor compares them whenever any observed output changes.
module tb_game_level_fsm;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  lvl;
    logic [2:0]  left;
    logic [10:0] spd;
    logic [3:0]  trees;
    logic [4:0]  ovl;
    logic        nl;
    logic        rq;
    logic [10:0] sreq;
  } snap_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic [2:0]  currLife;
  logic [23:0] currentTime;
  logic [2:0]  shotEnemyCollision;
  logic        playerTrigger, pauseTrigger, transitionDone, slowClk;
  logic [2:0]  currentGameState, level, enemiesLeft;
  logic [10:0] curEnemySpeed, slowClkRequest;
  logic [3:0]  tree_count;
  logic        pause, start_screen, death_screen, transition_screen, victory_screen;
  logic        newLevel, requestTime;

  int    checks = 0;
  int    errors = 0;
  snap_t expQ[$];
  string tagQ[$];
  snap_t prevSnap;
  bit    havePrev = 0;

  localparam logic [23:0] T_OK = 24'd1000;

  game_level_fsm dut (
    .clk                (clk),
    .resetN             (resetN),
    .currLife           (currLife),
    .currentTime        (currentTime),
    .shotEnemyCollision (shotEnemyCollision),
    .playerTrigger      (playerTrigger),
    .pauseTrigger       (pauseTrigger),
    .transitionDone     (transitionDone),
    .slowClk            (slowClk),
    .currentGameState   (currentGameState),
    .level              (level),
    .enemiesLeft        (enemiesLeft),
    .curEnemySpeed      (curEnemySpeed),
    .tree_count         (tree_count),
    .pause              (pause),
    .start_screen       (start_screen),
    .death_screen       (death_screen),
    .transition_screen  (transition_screen),
    .victory_screen     (victory_screen),
    .newLevel           (newLevel),
    .requestTime        (requestTime),
    .slowClkRequest     (slowClkRequest)
  );

  always #5 clk = ~clk;

  // Expected outputs built from the state, level and enemy count alone.
  function automatic snap_t mkSnap(input int st, input int lvl, input int left, input bit rq);
    snap_t s;
    int    spd, trees;
    spd = 120 + 120 * lvl;
    if (spd > 2047) spd = 2047;
    trees = 8 + lvl;
    if (trees > 15) trees = 15;
    s.st    = 3'(st);
    s.lvl   = 3'(lvl);
    s.left  = 3'(left);
    s.spd   = 11'(spd);
    s.trees = 4'(trees);
    s.ovl   = {st != 1, st == 0, st == 5, st == 6, st == 4};
    s.nl    = (st == 2);
    s.rq    = rq;
    s.sreq  = rq ? 11'd120 : 11'd0;
    return s;
  endfunction

  function automatic snap_t capture();
    snap_t s;
    s.st    = currentGameState;
    s.lvl   = level;
    s.left  = enemiesLeft;
    s.spd   = curEnemySpeed;
    s.trees = tree_count;
    s.ovl   = {pause, start_screen, death_screen, transition_screen, victory_screen};
    s.nl    = newLevel;
    s.rq    = requestTime;
    s.sreq  = slowClkRequest;
    return s;
  endfunction

  task automatic expectSnap(input string tag, input int st, input int lvl, input int left, input bit rq);
    expQ.push_back(mkSnap(st, lvl, left, rq));
    tagQ.push_back(tag);
  endtask

  task automatic checkOutput(input string tag, input snap_t act, input snap_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got st=%0d lvl=%0d left=%0d spd=%0d trees=%0d ovl=%b nl=%b rq=%b sreq=%0d, expected st=%0d lvl=%0d left=%0d spd=%0d trees=%0d ovl=%b nl=%b rq=%b sreq=%0d",
               tag, act.st, act.lvl, act.left, act.spd, act.trees, act.ovl, act.nl, act.rq, act.sreq,
               exp.st, exp.lvl, exp.left, exp.spd, exp.trees, exp.ovl, exp.nl, exp.rq, exp.sreq);
    end
  endtask

  // Monitor: any change of the observed outputs is one scoreboard event.
  always @(negedge clk) begin
    snap_t cur, e;
    string t;
    if (resetN === 1'b1) begin
      cur = capture();
      if (!havePrev || cur !== prevSnap) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_change: got st=%0d lvl=%0d left=%0d, expected no change",
                   cur.st, cur.lvl, cur.left);
        end else begin
          e = expQ.pop_front();
          t = tagQ.pop_front();
          checkOutput(t, cur, e);
        end
      end
      prevSnap = cur;
      havePrev = 1;
    end
  end

  task automatic applyStimulus(input logic [2:0] shot, input logic trig, input logic pauseT,
                               input logic tDone, input logic sClk,
                               input logic [2:0] life, input logic [23:0] tm);
    shotEnemyCollision = shot;
    playerTrigger      = trig;
    pauseTrigger       = pauseT;
    transitionDone     = tDone;
    slowClk            = sClk;
    currLife           = life;
    currentTime        = tm;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, 0, 0, 0, 0, 3'd3, T_OK);
  endtask

  // Enter LOAD (from START via trigger, or from TRANSITION via transitionDone),
  // offer a slowClk in the first LOAD cycle (must be ignored), then start PLAY.
  task automatic loadLevel(input int lvl, input int left, input bit viaTrigger);
    expectSnap($sformatf("load%0d_first", lvl), 2, lvl, left, 1);
    expectSnap($sformatf("load%0d_hold", lvl), 2, lvl, left, 0);
    expectSnap($sformatf("play%0d", lvl), 1, lvl, left, 0);
    applyStimulus(3'b000, viaTrigger, 0, !viaTrigger, 0, 3'd3, T_OK);
    applyStimulus(3'b000, 0, 0, 0, 1, 3'd3, T_OK);
    applyStimulus(3'b000, 0, 0, 0, 1, 3'd3, T_OK);
    idle(1);
  endtask

  initial begin
    int waitC;
    resetN             = 1'b0;
    shotEnemyCollision = 3'b000;
    playerTrigger      = 1'b0;
    pauseTrigger       = 1'b0;
    transitionDone     = 1'b0;
    slowClk            = 1'b0;
    currLife           = 3'd3;
    currentTime        = T_OK;
    expectSnap("reset", 0, 0, 2, 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    idle(2);

    // Level 0: single kills on separate cycles
    loadLevel(0, 2, 1);
    expectSnap("kill_l0_a", 1, 0, 1, 0);
    applyStimulus(3'b001, 0, 0, 0, 0, 3'd3, T_OK);
    idle(1);
    expectSnap("clear_l0", 6, 0, 0, 0);
    applyStimulus(3'b010, 0, 0, 0, 0, 3'd3, T_OK);
    idle(2);

    // Level 1: a triple hit against two remaining saturates at zero
    loadLevel(1, 3, 0);
    expectSnap("kill_l1", 1, 1, 2, 0);
    applyStimulus(3'b001, 0, 0, 0, 0, 3'd3, T_OK);
    expectSnap("sat_clear_l1", 6, 1, 0, 0);
    applyStimulus(3'b111, 0, 0, 0, 0, 3'd3, T_OK);
    idle(2);

    // Level 2: pause ignores collisions and timeout
    loadLevel(2, 4, 0);
    expectSnap("paused", 3, 2, 4, 0);
    applyStimulus(3'b000, 0, 1, 0, 0, 3'd3, T_OK);
    applyStimulus(3'b011, 0, 1, 0, 0, 3'd3, 24'd0);
    applyStimulus(3'b111, 0, 0, 0, 0, 3'd0, T_OK);
    expectSnap("resumed", 1, 2, 4, 0);
    applyStimulus(3'b000, 0, 1, 0, 0, 3'd3, T_OK);
    idle(1);
    expectSnap("kill_l2", 1, 2, 1, 0);
    applyStimulus(3'b111, 0, 0, 0, 0, 3'd3, T_OK);
    expectSnap("clear_l2", 6, 2, 0, 0);
    applyStimulus(3'b001, 0, 0, 0, 0, 3'd3, T_OK);
    idle(1);

    // Level 3 (last): clear in the same cycle lives reach zero
    loadLevel(3, 5, 0);
    expectSnap("kill_l3", 1, 3, 2, 0);
    applyStimulus(3'b111, 0, 0, 0, 0, 3'd3, T_OK);
    expectSnap("victory", 4, 3, 0, 0);
    applyStimulus(3'b011, 0, 0, 0, 0, 3'd0, T_OK);
    idle(1);
    expectSnap("restart_from_victory", 0, 0, 2, 0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1, 0, 0, 0, 3'd3, T_OK);
    idle(1);

    // Timeout death, then a held trigger must advance exactly once
    loadLevel(0, 2, 1);
    expectSnap("death_timeout", 5, 0, 2, 0);
    applyStimulus(3'b000, 0, 0, 0, 0, 3'd3, 24'd0);
    expectSnap("start_after_death", 0, 0, 2, 0);
    for (int i = 0; i < 10; i++) applyStimulus(3'b000, 1, 0, 0, 0, 3'd3, 24'd0);
    idle(2);

    // Death wins over a simultaneous pause edge
    loadLevel(0, 2, 1);
    expectSnap("death_over_pause", 5, 0, 2, 0);
    applyStimulus(3'b000, 0, 1, 0, 0, 3'd0, T_OK);
    idle(1);
    expectSnap("start_after_death2", 0, 0, 2, 0);
    applyStimulus(3'b000, 1, 0, 0, 0, 3'd3, T_OK);
    idle(1);

    // Asynchronous reset in the middle of a level
    loadLevel(0, 2, 1);
    expectSnap("kill_before_reset", 1, 0, 1, 0);
    applyStimulus(3'b001, 0, 0, 0, 0, 3'd3, T_OK);
    idle(1);
    expectSnap("after_reset", 0, 0, 2, 0);
    resetN = 1'b0;
    #1;
    checks++;
    if (currentGameState !== 3'd0 || enemiesLeft !== 3'd2) begin
      errors++;
      $display("[TB] FAIL async_reset: got st=%0d left=%0d, expected st=0 left=2",
               currentGameState, enemiesLeft);
    end
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    idle(3);

    waitC = 0;
    while (expQ.size() > 0 && waitC < 50) begin
      @(posedge clk);
      waitC++;
    end
    while (expQ.size() > 0) begin
      snap_t e;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no output event, expected st=%0d lvl=%0d left=%0d",
               t, e.st, e.lvl, e.left);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_level_fsm.md
Name: game_level_fsm

Overview:
- Top-level game flow controller for the game core; parametrised successor of the fixed two-level flow.
- Sequences start screen -> N levels (play / transition / level load) -> victory or death, with an optional player pause.
- Tracks remaining enemies per level from collision pulses and scales enemy speed and tree count per level.
- Drives the screen overlays, the timer request and the slow-clock request.

Parameters:
- NUM_LEVELS, 4, number of playable levels (2..8)
- BASE_ENEMIES, 2, enemies in level 0
- MAX_ENEMIES, 7, cap on enemies per level; level L has min(BASE_ENEMIES+L, MAX_ENEMIES)
- SHOT_W, 3, number of per-enemy collision lines
- SPEED_BASE, 120, enemy speed in level 0
- SPEED_STEP, 120, speed increment per level; result saturates at 11'h7FF
- TREES_BASE, 8, tree count in level 0; +1 per level, saturating at 15
- LOAD_TICKS, 120, slowClkRequest value issued on level load

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- currLife  in  3  player lives remaining
- currentTime  in  24  level timer; 0 means timeout
- shotEnemyCollision  in  SHOT_W  one bit per enemy hit this cycle
- playerTrigger  in  1  fire/confirm button (level)
- pauseTrigger  in  1  pause button (level)
- transitionDone  in  1  transition animation finished
- slowClk  in  1  one-cycle tick from the slow-clock divider
- currentGameState  out  3  0 start, 1 play, 2 load, 3 paused, 4 victory, 5 death, 6 transition
- level  out  3  current level index
- enemiesLeft  out  3  enemies remaining in the current level
- curEnemySpeed  out  11  enemy speed for the current level
- tree_count  out  4  trees for the current level
- pause, start_screen, death_screen, transition_screen, victory_screen  out  1 each  overlay and freeze controls
- newLevel  out  1  pulse: reinitialise level objects
- requestTime  out  1  pulse: reload level timer
- slowClkRequest  out  11  slow-clock period request; nonzero only during the request cycle

Behaviour:
- Reset: state START, level=0, enemiesLeft=BASE_ENEMIES, pause=1, start_screen=1, all other outputs 0; curEnemySpeed=SPEED_BASE, tree_count=TREES_BASE.
- Buttons: playerTrigger and pauseTrigger are rising-edge detected with a registered previous value. Holding a button never advances more than one state.
- playerDead = (currLife==0) || (currentTime==0).
- kills = popcount(shotEnemyCollision). enemiesLeft decrements by kills in PLAY only and saturates at 0.
- States and transitions, all registered:
  - START: on trigger edge, level<=0, enemiesLeft<=count(0), go to LOAD.
  - LOAD: first cycle has requestTime=1 and slowClkRequest=LOAD_TICKS; every cycle in LOAD has newLevel=1. On slowClk, go to PLAY. A slowClk in the first LOAD cycle is ignored.
  - PLAY:
    - If kills>=enemiesLeft: go to VICTORY if level==NUM_LEVELS-1, else TRANSITION.
    - Otherwise, if playerDead: go to DEATH.
    - Otherwise, on pause edge: go to PAUSED.
    - Clear has priority over death in the same cycle; death has priority over pause.
  - PAUSED: on pause edge, return to PLAY. Collisions and playerDead are ignored while paused.
  - TRANSITION: on transitionDone, level<=level+1, enemiesLeft<=count(level+1), go to LOAD.
  - VICTORY / DEATH: on trigger edge, go to START. level and enemiesLeft reload to reset values on entry to START.
- Outputs:
  - Overlay outputs, newLevel and requestTime are combinational from the registered state.
  - pause=1 in every state except PLAY.
  - curEnemySpeed = sat(SPEED_BASE + level*SPEED_STEP).
  - tree_count = sat(TREES_BASE + level).
  - The curEnemySpeed and tree_count arithmetic uses 16-bit intermediates.
- Illegal state encodings return to START on the next clock.
- Reset mid-level returns to START within the same cycle (asynchronous).

Decomposition:
- Package game_pkg holds:
  - the game_state_e enum with explicit 3-bit encodings matching currentGameState;
  - function enemies_for_level(level);
  - the saturation constants.
- One sub-module, edge_detect: a registered rising-edge pulse, instantiated twice (trigger and pause).
- Popcount and the speed/tree math stay inline.

Test Plan:
- Reset then trigger edge -> state 2 with requestTime=1 and slowClkRequest=120 for one cycle; slowClk -> state 1, level=0, enemiesLeft=2, speed=120, tree_count=8.
- Level 0: two single-bit collisions on separate cycles -> enemiesLeft 2->1->0, state 6; transitionDone -> state 2, level=1, enemiesLeft=3, speed=240, tree_count=9.
- shotEnemyCollision=3'b111 with enemiesLeft=2 -> saturates, level cleared in one cycle, no underflow wrap.
- Final level cleared in the same cycle that currLife reaches 0 -> state 4 (victory wins); trigger edge -> state 0, level=0.
- Pause edge in PLAY -> state 3, pause=1, collisions ignored; second pause edge -> state 1 with enemiesLeft unchanged.
- currentTime=0 in PLAY -> state 5, death_screen=1; trigger held high for 10 cycles -> exactly one transition, to state 0.
